// File: rtl/cve2_lsu_sram_bridge.sv
// LSU data-bus slave bridging req/gnt/rvalid onto a 1-cycle SRAM.
// One transaction in flight; optional wait states; out-of-window -> error.
module cve2_lsu_sram_bridge #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic                  data_err_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [3:0]            sram_be_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned HI = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_LAST =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic capture;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  in_range_q;

  logic in_range;
  logic accept;
  logic do_access;
  logic unused_addr_lsb;

  // Byte-offset bits carry no meaning for word accesses.
  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign in_range = (data_addr_i[31:HI] == BASE_ADDR[31:HI]);

  // A new request is accepted only when idle or finishing a response.
  assign accept = rst_ni & data_req_i &
                  ((state_q == ST_IDLE) | (state_q == ST_RESP));

  // Next-state and wait counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          capture = 1'b1;
          cnt_d   = 4'd0;
          state_d = HAS_WAIT ? ST_WAIT : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and wait counter with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are latched at grant; the LSU may change its bus after.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      in_range_q <= 1'b0;
    end else if (capture) begin
      addr_q     <= data_addr_i[HI-1:2];
      we_q       <= data_we_i;
      be_q       <= data_be_i;
      wdata_q    <= data_wdata_i;
      in_range_q <= in_range;
    end
  end

  // SRAM strobe only for in-window accesses with some lane enabled.
  always_comb begin
    do_access    = rst_ni & (state_q == ST_ACCESS) &
                   in_range_q & (|be_q);
    sram_req_o   = do_access;
    sram_we_o    = do_access & we_q;
    sram_addr_o  = do_access ? addr_q : '0;
    sram_be_o    = do_access ? be_q : 4'd0;
    sram_wdata_o = (do_access & we_q) ? wdata_q : 32'd0;
  end

  // Bus-side handshake and response; read data only for real reads.
  always_comb begin
    data_gnt_o    = accept;
    data_rvalid_o = rst_ni & (state_q == ST_RESP);
    data_err_o    = data_rvalid_o & ~in_range_q;
    data_rdata_o  = 32'd0;
    if (data_rvalid_o & in_range_q & ~we_q & (|be_q)) begin
      data_rdata_o = sram_rdata_i;
    end
    busy_o = rst_ni & (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_cve2_lsu_sram_bridge.sv
// Bench for cve2_lsu_sram_bridge: three configurations, directed vectors,
// hand-written multi-cycle sequences and random traffic against a model.
module tb_cve2_lsu_sram_bridge;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [ND];
  logic        req   [ND];
  logic        we    [ND];
  logic [3:0]  be    [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wdata [ND];
  logic        gnt   [ND];
  logic        rvalid[ND];
  logic        err   [ND];
  logic [31:0] rdata [ND];
  logic        sreq  [ND];
  logic        swe   [ND];
  logic [3:0]  sbe   [ND];
  logic [31:0] swdata[ND];
  logic [31:0] srdata[ND];
  logic        busy  [ND];
  logic [9:0]  saddr [ND];
  logic [9:0]  saddr0, saddr2;
  logic [7:0]  saddr1;

  always_comb begin
    saddr[0] = saddr0;
    saddr[1] = {2'b00, saddr1};
    saddr[2] = saddr2;
  end

  cve2_lsu_sram_bridge #(
    .ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)
  ) u_w0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .data_req_i(req[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_err_o(err[0]),
    .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]),
    .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]),
    .sram_req_o(sreq[0]), .sram_we_o(swe[0]), .sram_addr_o(saddr0),
    .sram_be_o(sbe[0]), .sram_wdata_o(swdata[0]),
    .sram_rdata_i(srdata[0]), .busy_o(busy[0])
  );

  cve2_lsu_sram_bridge #(
    .ADDR_WIDTH(8), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3)
  ) u_w3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .data_req_i(req[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_err_o(err[1]),
    .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]),
    .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]),
    .sram_req_o(sreq[1]), .sram_we_o(swe[1]), .sram_addr_o(saddr1),
    .sram_be_o(sbe[1]), .sram_wdata_o(swdata[1]),
    .sram_rdata_i(srdata[1]), .busy_o(busy[1])
  );

  cve2_lsu_sram_bridge #(
    .ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(2)
  ) u_w2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .data_req_i(req[2]),
    .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_err_o(err[2]),
    .data_addr_i(addr[2]), .data_we_i(we[2]), .data_be_i(be[2]),
    .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]),
    .sram_req_o(sreq[2]), .sram_we_o(swe[2]), .sram_addr_o(saddr2),
    .sram_be_o(sbe[2]), .sram_wdata_o(swdata[2]),
    .sram_rdata_i(srdata[2]), .busy_o(busy[2])
  );

  function automatic int wc(input int d);
    case (d)
      0: return 0;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int aw(input int d);
    return (d == 1) ? 8 : 10;
  endfunction

  function automatic logic [31:0] base(input int d);
    case (d)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      default: return 32'h0000_1000;
    endcase
  endfunction

  // Behavioural SRAM per DUT; idle cycles return garbage on the read bus.
  logic [31:0] sram [ND][1024];
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (sreq[d] && swe[d])
        for (int b = 0; b < 4; b++)
          if (sbe[d][b]) sram[d][saddr[d]][8*b +: 8] <= swdata[d][8*b +: 8];
      srdata[d] <= (sreq[d] && !swe[d]) ? sram[d][saddr[d]] : $urandom;
    end
  end

  logic [31:0] ref_mem [ND][1024];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // SRAM data outputs must be quiet whenever no strobe is issued.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst_n[d] === 1'b1 && sreq[d] === 1'b0)
        chk($sformatf("d%0d sram idle quiet", d),
            {28'd0, swe[d], |saddr[d], |sbe[d], |swdata[d]}, 32'd0);
    end
  end

  // Reference: window check, byte-lane merge, reads return full word.
  function automatic void model(input int d, input logic [31:0] a,
      input logic w, input logic [3:0] b, input logic [31:0] wd,
      output logic e, output logic [31:0] rd, output logic stb);
    int sh;
    int word;
    sh   = aw(d) + 2;
    word = int'((a >> 2) & ((32'd1 << aw(d)) - 1));
    e    = ((a >> sh) != (base(d) >> sh));
    stb  = !e && (b != 4'd0);
    rd   = 32'd0;
    if (stb) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) ref_mem[d][word][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = ref_mem[d][word];
      end
    end
  endfunction

  // One transaction; request held (with scrambled fields) until response.
  task automatic run(input int d, input logic [31:0] a, input logic w,
      input logic [3:0] b, input logic [31:0] wd, input logic exp_e,
      input logic [31:0] exp_rd, input logic exp_stb, input string nm);
    int k, lat, stb_at, n_stb, el;
    logic [31:0] got_rd, stb_wd;
    logic got_e, stb_we;
    logic [9:0] stb_addr;
    logic [3:0] stb_be;
    el = wc(d) + 2;
    got_rd = 0; got_e = 0; stb_wd = 0; stb_we = 0; stb_addr = 0;
    stb_be = 0;
    @(posedge clk); #1;
    req[d] = 1'b1; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd;
    k = 0;
    @(negedge clk);
    while (!gnt[d] && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk({nm, " gnt"}, {31'd0, gnt[d]}, 32'd1);
    chk({nm, " gnt wait"}, k, 0);
    if (!gnt[d]) begin
      req[d] = 1'b0;
      return;
    end
    lat = 0; stb_at = -1; n_stb = 0;
    for (int c = 1; c <= el + 3 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        addr[d] = $urandom; wdata[d] = $urandom;
        we[d] = ~w; be[d] = ~b;
      end
      if (c >= el) req[d] = 1'b0;
      @(negedge clk);
      if (sreq[d]) begin
        n_stb++; stb_at = c; stb_addr = saddr[d];
        stb_we = swe[d]; stb_be = sbe[d]; stb_wd = swdata[d];
      end
      if (rvalid[d]) begin
        lat = c; got_rd = rdata[d]; got_e = err[d];
      end else begin
        chk({nm, " gnt low"}, {31'd0, gnt[d]}, 32'd0);
      end
      chk({nm, " busy"}, {31'd0, busy[d]}, 32'd1);
    end
    req[d] = 1'b0;
    chk({nm, " latency"}, lat, el);
    chk({nm, " err"}, {31'd0, got_e}, {31'd0, exp_e});
    chk({nm, " rdata"}, got_rd, exp_rd);
    chk({nm, " strobes"}, n_stb, {31'd0, exp_stb});
    if (exp_stb && n_stb == 1) begin
      chk({nm, " strobe cycle"}, stb_at, el - 1);
      chk({nm, " sram addr"}, {22'd0, stb_addr},
          (a >> 2) & ((32'd1 << aw(d)) - 1));
      chk({nm, " sram we"}, {31'd0, stb_we}, {31'd0, w});
      chk({nm, " sram be"}, {28'd0, stb_be}, {28'd0, b});
      if (w) chk({nm, " sram wdata"}, stb_wd, wd);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, " busy after"}, {31'd0, busy[d]}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [3:0]  b;
    logic [31:0] wd;
    logic        e;
    logic [31:0] rd;
    logic        stb;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [15];
    logic e, stb, ie, istb;
    logic [31:0] rd, ird, a, wd;
    logic w;
    logic [3:0] b;
    int cnt;

    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 1024; i++) begin
        wd = (d == 0) ? 32'd0 : $urandom;
        sram[d][i] <= wd;
        ref_mem[d][i] = wd;
      end
      rst_n[d] = 1'b0; req[d] = 1'b1; we[d] = 1'b0; be[d] = 4'hF;
      addr[d] = 32'd0; wdata[d] = 32'd0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      chk($sformatf("d%0d outputs in reset", d),
          {22'd0, gnt[d], rvalid[d], err[d], sreq[d], swe[d], busy[d],
           |rdata[d], |saddr[d], |sbe[d], |swdata[d]}, 32'd0);
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      rst_n[d] = 1'b1; req[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      chk($sformatf("d%0d outputs after reset", d),
          {22'd0, gnt[d], rvalid[d], err[d], sreq[d], swe[d], busy[d],
           |rdata[d], |saddr[d], |sbe[d], |swdata[d]}, 32'd0);

    tv[0]  = '{32'h0000_0014, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1};
    tv[1]  = '{32'h0000_0014, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1};
    tv[2]  = '{32'h0000_0010, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b1};
    tv[3]  = '{32'h0000_0020, 1'b1, 4'hF, 32'h1122_3344, 1'b0, 32'h0, 1'b1};
    tv[4]  = '{32'h0000_0020, 1'b1, 4'h4, 32'h00AB_0000, 1'b0, 32'h0, 1'b1};
    tv[5]  = '{32'h0000_0020, 1'b0, 4'hF, 32'h0, 1'b0, 32'h11AB_3344, 1'b1};
    tv[6]  = '{32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0};
    tv[7]  = '{32'h0000_2000, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0};
    tv[8]  = '{32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1};
    tv[9]  = '{32'h0000_0014, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0};
    tv[10] = '{32'h0000_0014, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0};
    tv[11] = '{32'h0000_0017, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1};
    tv[12] = '{32'h0000_0FFC, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b1};
    tv[13] = '{32'h0000_0FFC, 1'b0, 4'h3, 32'h0, 1'b0, 32'h1234_5678, 1'b1};
    tv[14] = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      model(0, tv[i].a, tv[i].w, tv[i].b, tv[i].wd, ie, ird, istb);
      run(0, tv[i].a, tv[i].w, tv[i].b, tv[i].wd, tv[i].e, tv[i].rd,
          tv[i].stb, $sformatf("vec%0d", i));
    end

    // Back-to-back reads of two adjacent words with req held high.
    @(posedge clk); #1;
    req[0] = 1'b1; addr[0] = 32'h10; we[0] = 1'b0; be[0] = 4'hF;
    @(negedge clk);
    chk("b2b gnt1", {31'd0, gnt[0]}, 32'd1);
    @(posedge clk); #1;
    addr[0] = 32'h14;
    @(negedge clk);
    chk("b2b gnt idle", {31'd0, gnt[0]}, 32'd0);
    chk("b2b strobe1", {21'd0, sreq[0], saddr[0]}, {21'd0, 1'b1, 10'd4});
    chk("b2b busy1", {31'd0, busy[0]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b rvalid1", {31'd0, rvalid[0]}, 32'd1);
    chk("b2b rdata1", rdata[0], 32'h0BAD_F00D);
    chk("b2b gnt2", {31'd0, gnt[0]}, 32'd1);
    chk("b2b busy2", {31'd0, busy[0]}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("b2b gap rvalid", {31'd0, rvalid[0]}, 32'd0);
    chk("b2b strobe2", {21'd0, sreq[0], saddr[0]}, {21'd0, 1'b1, 10'd5});
    chk("b2b busy3", {31'd0, busy[0]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b rvalid2", {31'd0, rvalid[0]}, 32'd1);
    chk("b2b rdata2", rdata[0], 32'hDEAD_BEEF);
    chk("b2b busy4", {31'd0, busy[0]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b busy end", {31'd0, busy[0]}, 32'd0);

    // Wait-state configuration: write then read back one word.
    model(1, 32'h8000_0010, 1'b1, 4'hF, 32'hA5A5_5A5A, e, rd, stb);
    run(1, 32'h8000_0010, 1'b1, 4'hF, 32'hA5A5_5A5A, e, rd, stb, "w3 wr");
    model(1, 32'h8000_0010, 1'b0, 4'hF, 32'h0, e, rd, stb);
    run(1, 32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 32'hA5A5_5A5A, 1'b1,
        "w3 rd");

    // Reset one cycle after grant drops the transaction entirely.
    @(posedge clk); #1;
    req[2] = 1'b1; addr[2] = 32'h1014; we[2] = 1'b0; be[2] = 4'hF;
    @(negedge clk);
    chk("rst gnt", {31'd0, gnt[2]}, 32'd1);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("rst mid outputs",
        {22'd0, gnt[2], rvalid[2], err[2], sreq[2], swe[2], busy[2],
         |rdata[2], |saddr[2], |sbe[2], |swdata[2]}, 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1; req[2] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid[2] || sreq[2] || busy[2]) cnt++;
    end
    chk("rst no activity", cnt, 0);
    model(2, 32'h1014, 1'b0, 4'hF, 32'h0, e, rd, stb);
    run(2, 32'h1014, 1'b0, 4'hF, 32'h0, e, rd, stb, "rst after");

    // Random traffic on every configuration against the model.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 4) != 0)
          a = base(d) + ((($urandom) & ((32'd1 << aw(d)) - 1)) << 2)
              + 32'($urandom_range(0, 3));
        else
          a = $urandom;
        w  = 1'($urandom_range(0, 1));
        b  = 4'($urandom_range(0, 15));
        wd = $urandom;
        model(d, a, w, b, wd, e, rd, stb);
        run(d, a, w, b, wd, e, rd, stb, $sformatf("rnd d%0d n%0d", d, n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cve2_lsu_sram_bridge.md
Name: cve2_lsu_sram_bridge

Overview:
Slave-side bridge directly downstream of the core load/store unit. It terminates the LSU data-bus req/gnt/rvalid handshake and drives a single-port, 1-cycle-read-latency, byte-enabled SRAM. It inserts configurable wait states and flags accesses outside its address window as bus errors. At most one transaction is outstanding at any time.

Parameters:
ADDR_WIDTH, 10, SRAM word-address bits; window size = 4*2^ADDR_WIDTH bytes
BASE_ADDR, 32'h0000_0000, window base; must be aligned to window size
WAIT_CYCLES, 0, extra cycles between grant and SRAM access (0..15)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
data_req_i  in  1  LSU request
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid, one-cycle pulse
data_err_o  out  1  response is an error; qualified by data_rvalid_o
data_addr_i  in  32  word-aligned byte address
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data, already lane-aligned
data_rdata_o  out  32  read data; qualified by data_rvalid_o
sram_req_o  out  1  SRAM access strobe
sram_we_o  out  1  SRAM write
sram_addr_o  out  ADDR_WIDTH  SRAM word address
sram_be_o  out  4  SRAM byte enables
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data, valid the cycle after a read strobe
busy_o  out  1  transaction outstanding

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset: FSM to IDLE, wait counter to 0, captured request fields to 0. All outputs are 0 during and after reset.
- FSM states:
  - IDLE: data_gnt_o = data_req_i. On grant, capture addr/we/be/wdata and the in-range flag. Go to WAIT if WAIT_CYCLES > 0, otherwise ACCESS.
  - WAIT: counter counts up from 0. At WAIT_CYCLES-1, go to ACCESS.
  - ACCESS: sram_req_o = in_range & (be != 0). sram_we_o, sram_addr_o, sram_be_o and sram_wdata_o come from the captured fields, not from the live inputs. Go to RESP.
  - RESP: data_rvalid_o = 1. data_err_o = ~in_range. data_rdata_o = sram_rdata_i for an in-range read, else 32'h0. data_gnt_o = data_req_i in RESP too (back-to-back): on grant, capture the new request and go to WAIT/ACCESS; otherwise go to IDLE.
- Latency: grant at cycle T, SRAM strobe at T+1+WAIT_CYCLES, rvalid at T+2+WAIT_CYCLES.
- data_gnt_o is never asserted in WAIT or ACCESS. data_req_i may stay high across those states; the LSU holds its request while waiting for the previous response.
- Range check: in_range = (data_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]). sram_addr_o = addr[ADDR_WIDTH+1:2]. Address bits [1:0] are ignored.
- Out-of-range: no SRAM strobe. The same latency applies, then rvalid with err=1 and rdata=0.
- be == 0: the request is granted, no SRAM strobe, and a normal non-error response is returned. A read with be == 0 returns rdata 0.
- Write responses: rdata = 0; err only if out of range.
- sram_* data outputs are 0 whenever sram_req_o = 0.
- busy_o = 1 in WAIT, ACCESS and RESP.
- Reset asserted mid-transaction: the pending transaction is dropped, with no rvalid and no SRAM strobe after the reset edge.
- data_gnt_o and data_rvalid_o are combinational from the state and data_req_i only. No combinational path exists from sram_rdata_i to any handshake output.

Test Plan:
- Single read, WAIT_CYCLES=0: write 32'hDEADBEEF to word 5, then read addr 0x14. Required: gnt at T, sram_req at T+1 with addr 5 and we=0, rvalid at T+2 with rdata 32'hDEADBEEF and err=0.
- Byte write: write addr 0x20 with be=4'b0100 and wdata 32'h00AB0000 over prior content 32'h11223344, then read back. Required: rdata 32'h11AB3344.
- Out-of-range, BASE_ADDR=0, ADDR_WIDTH=10: read 0x1000. Required: no sram_req, rvalid at T+2 with err=1 and rdata 0. A write to 0x2000 gives err=1 and leaves SRAM contents unchanged.
- Wait states, WAIT_CYCLES=3: read at T. Required: sram_req at T+4, rvalid at T+5; gnt stays low in T+1..T+4 while data_req_i is held high.
- Back-to-back (misaligned-split pattern): req held high across two words 0x10 and 0x14. Required: second gnt coincides with the first rvalid; second rvalid arrives two cycles later; busy_o stays high throughout.
- Reset mid-op, WAIT_CYCLES=2: drop rst_ni one cycle after grant. Required: next cycle all outputs 0, no rvalid afterwards, and a new request after reset release is granted immediately.
